// File: rtl/div.sv
// Sequential 32-bit integer divider, signed or unsigned.
// The radix-2 restoring core works on operand magnitudes for 32 cycles;
// a final FIX cycle applies signs, handles b=0 and signed overflow,
// and registers quotient, remainder and condition field.
package Pu_types;
  localparam int DWIDTH = 32;
  typedef logic [DWIDTH-1:0] Word;
  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic ov;
  } Cr_field;
endpackage

module div
  import Pu_types::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    start,
  input  logic    uns,
  input  Word     a,
  input  Word     b,
  output logic    ready,
  output logic    valid,
  output Word     quot,
  output Word     rem,
  output Cr_field crf
);

  typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

  state_t     state_reg, state_next;
  logic [5:0] cnt_reg;
  Word        a_reg;        // original dividend, returned as remainder on b=0
  Word        b_mag_reg;    // divisor magnitude
  Word        q_reg;        // dividend magnitude shifting out, quotient shifting in
  Word        r_reg;        // partial remainder
  logic       q_neg_reg;    // quotient must be negated
  logic       r_neg_reg;    // remainder must be negated
  logic       b_zero_reg;
  logic       ovf_reg;

  logic            accept;
  logic            a_neg, b_neg;
  Word             a_mag, b_mag;
  logic [DWIDTH:0] r_shift, r_trial;
  Word             quot_fix, rem_fix;
  Cr_field         crf_fix;

  assign accept = start && (state_reg == IDLE);

  // Operand signs only matter in signed mode.
  assign a_neg = ~uns & a[DWIDTH-1];
  assign b_neg = ~uns & b[DWIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One restoring step: bring in the next dividend bit, try to subtract.
  // r_shift < 2*divisor, so a borrow shows up as the top bit of r_trial.
  assign r_shift = {r_reg, q_reg[DWIDTH-1]};
  assign r_trial = r_shift - {1'b0, b_mag_reg};

  // Final result selection, including the two exceptional cases.
  always_comb begin
    quot_fix = q_neg_reg ? -q_reg : q_reg;
    rem_fix  = r_neg_reg ? -r_reg : r_reg;
    if (b_zero_reg) begin
      quot_fix = '0;
      rem_fix  = a_reg;
    end else if (ovf_reg) begin
      quot_fix = {1'b1, {(DWIDTH-1){1'b0}}};
      rem_fix  = '0;
    end
    crf_fix.lt = quot_fix[DWIDTH-1];
    crf_fix.eq = ~quot_fix[DWIDTH-1] && (quot_fix == '0);
    crf_fix.gt = ~quot_fix[DWIDTH-1] && (quot_fix != '0);
    crf_fix.ov = b_zero_reg | ovf_reg;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: fixed 32 iterations, no early-out.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (cnt_reg == 6'(DWIDTH-1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready = (state_reg == IDLE);
  end

  // Operand capture and iterative datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_mag_reg  <= '0;
      q_reg      <= '0;
      r_reg      <= '0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
      b_zero_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else if (accept) begin
      cnt_reg    <= '0;
      a_reg      <= a;
      b_mag_reg  <= b_mag;
      q_reg      <= a_mag;
      r_reg      <= '0;
      q_neg_reg  <= a_neg ^ b_neg;
      r_neg_reg  <= a_neg;
      b_zero_reg <= (b == '0);
      ovf_reg    <= ~uns && (a == {1'b1, {(DWIDTH-1){1'b0}}}) && (b == '1);
    end else if (state_reg == BUSY) begin
      cnt_reg <= cnt_reg + 6'd1;
      if (!r_trial[DWIDTH]) begin
        r_reg <= r_trial[DWIDTH-1:0];
        q_reg <= {q_reg[DWIDTH-2:0], 1'b1};
      end else begin
        r_reg <= r_shift[DWIDTH-1:0];
        q_reg <= {q_reg[DWIDTH-2:0], 1'b0};
      end
    end
  end

  // Result registers: loaded in FIX, held until the next result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      crf   <= '0;
    end else begin
      valid <= (state_reg == FIX);
      if (state_reg == FIX) begin
        quot <= quot_fix;
        rem  <= rem_fix;
        crf  <= crf_fix;
      end
    end
  end

endmodule

// File: tb/tb_div.sv
// Randomised and directed bench for the sequential divider, checked
// against a plain-arithmetic reference model.
module tb_div;
  import Pu_types::*;

  logic    clk = 1'b0;
  logic    reset = 1'b0;
  logic    start = 1'b0;
  logic    uns = 1'b0;
  Word     a = '0;
  Word     b = '0;
  logic    ready, valid;
  Word     quot, rem;
  Cr_field crf;

  int n_checks = 0;
  int n_fail   = 0;
  int op_num   = 0;

  always #5 clk = ~clk;

  div dut (
    .clk(clk), .reset(reset), .start(start), .uns(uns), .a(a), .b(b),
    .ready(ready), .valid(valid), .quot(quot), .rem(rem), .crf(crf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer division as defined arithmetically.
  task automatic ref_div(input bit u, input Word aa, input Word bb,
                         output Word q, output Word r, output logic [3:0] c);
    int  sa, sb;
    bit  ov;
    ov = 1'b0;
    if (bb == 0) begin
      q = 0; r = aa; ov = 1'b1;
    end else if (!u && aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0; ov = 1'b1;
    end else if (u) begin
      q = aa / bb; r = aa % bb;
    end else begin
      sa = aa; sb = bb;
      q = sa / sb; r = sa % sb;
    end
    // {lt, gt, eq, ov}
    if (q[31])       c = {3'b100, ov};
    else if (q == 0) c = {3'b001, ov};
    else             c = {3'b010, ov};
  endtask

  // Issue one operation (optionally injecting an ignored start at edge
  // 'inject') and check latency and result. Returns 1 time unit after the
  // edge that raised valid, with ready expected high.
  task automatic run_op(input bit u, input Word aa, input Word bb,
                        input int inject, input bit tail);
    Word        eq_q, eq_r;
    logic [3:0] eq_c;
    int         lat, busy_ready, extra;
    Word        held;
    check("ready_idle", 64'(ready), 64'(1));
    ref_div(u, aa, bb, eq_q, eq_r, eq_c);
    uns = u; a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    uns = 1'($urandom); a = $urandom; b = $urandom;
    lat = 0; busy_ready = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      if (n == inject) begin start = 1'b1; uns = 1'b1; a = 9; b = 3; end
      if (n == inject + 1) start = 1'b0;
      @(posedge clk); #1;
      if (valid) lat = n;
      else if (ready) busy_ready++;
    end
    check("latency", 64'(lat), 64'(33));
    check("ready_busy", 64'(busy_ready), 64'(0));
    check("quot", 64'(quot), 64'(eq_q));
    check("rem", 64'(rem), 64'(eq_r));
    check("crf", 64'(crf), 64'(eq_c));
    check("ready_at_valid", 64'(ready), 64'(1));
    op_num++;
    $display("op %0d uns=%0d a=%08h b=%08h -> quot=%08h rem=%08h crf=%04b lat=%0d",
             op_num, u, aa, bb, quot, rem, crf, lat);
    if (tail) begin
      held = quot;
      extra = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (valid) extra++;
      end
      check("single_valid", 64'(extra), 64'(0));
      check("quot_held", 64'(quot), 64'(held));
    end
  endtask

  initial begin
    int  sel, vcnt;
    bit  u;
    Word ra, rb;

    // Reset state
    #23;
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_quot", 64'(quot), 64'(0));
    check("rst_rem", 64'(rem), 64'(0));
    check("rst_crf", 64'(crf), 64'(0));
    @(negedge clk); reset = 1'b1;

    // Directed cases
    run_op(1'b1, 32'd100, 32'd7, 0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(1'b1, 32'd5, 32'd0, 0, 1'b1);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 10, 1'b1);
    // Back-to-back: second start accepted on the edge after valid
    run_op(1'b1, 32'd1000, 32'd10, 0, 1'b0);
    run_op(1'b1, 32'd9, 32'd3, 0, 1'b0);

    // Mid-operation reset
    uns = 1'b1; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_ready", 64'(ready), 64'(1));
    check("abort_valid", 64'(valid), 64'(0));
    check("abort_quot", 64'(quot), 64'(0));
    check("abort_rem", 64'(rem), 64'(0));
    check("abort_crf", 64'(crf), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) vcnt++;
    end
    check("abort_no_valid", 64'(vcnt), 64'(0));
    run_op(1'b1, 32'd0, 32'd4, 0, 1'b0);

    // Random operations
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 9));
      u   = 1'($urandom);
      ra  = $urandom;
      case (sel)
        0:       rb = 0;
        1:       begin u = 1'b0; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = $urandom_range(1, 15);
        3:       rb = -Word'($urandom_range(1, 15));
        4:       begin ra = $urandom_range(0, 50); rb = $urandom; end
        default: rb = $urandom;
      endcase
      run_op(u, ra, rb, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
